// File: rtl/outport_alloc.sv
// Output-port switch allocator: round-robin head arbitration, wormhole lock until tail, credit gating.
// Zero-cycle grant (combinational from registers and inputs); a flit moves only while a downstream credit is held.
package noc_pkg;
  localparam int PORT_N = 5;
  localparam int PORT_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;
endpackage

module outport_alloc
  import noc_pkg::*;
#(
  parameter  int PORTID = 0,
  parameter  int CRED_N = 4,
  localparam int CRED_W = $clog2(CRED_N + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORT_N-1:0]        req_i,
  input  logic [PORT_N*PORT_W-1:0] port_i,
  input  logic [PORT_N-1:0]        head_i,
  input  logic [PORT_N-1:0]        tail_i,
  input  logic                     credit_i,
  output logic [PORT_N-1:0]        sel_o,
  output logic [PORT_N-1:0]        grt_o,
  output logic                     valid_o,
  output logic                     busy_o,
  output logic [CRED_W-1:0]        credits_o,
  output logic                     err_o
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [PORT_W-1:0] PID  = PORT_W'(PORTID);
  localparam logic [CRED_W-1:0] CMAX = CRED_W'(CRED_N);

  state_t              state_q, state_d;
  logic [PORT_W-1:0]   owner_q, owner_d;
  logic [PORT_W-1:0]   ptr_q, ptr_d;
  logic [CRED_W-1:0]   cred_q, cred_d;
  logic                err_q, err_d;

  logic [PORT_N-1:0]   cand;
  logic                ok;
  logic                win_vld;
  logic [PORT_W-1:0]   win_idx;
  logic [PORT_N-1:0]   grt_c, sel_c;
  logic                xfer;

  // Index increment that wraps at PORT_N-1, so non-power-of-2 port counts stay in range.
  function automatic logic [PORT_W-1:0] inc_wrap(input logic [PORT_W-1:0] v);
    return (v == PORT_W'(PORT_N - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < PORT_N; i++) begin
      cand[i] = req_i[i] & head_i[i] & (port_i[i*PORT_W +: PORT_W] == PID);
    end
  end

  assign ok = (cred_q != '0);

  // Search starts at ptr_q and wraps; the first candidate found wins.
  always_comb begin
    int                idx;
    logic [PORT_W-1:0] idx_v;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    idx_v   = '0;
    for (int k = 0; k < PORT_N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= PORT_N) idx = idx - PORT_N;
      idx_v = PORT_W'(idx);
      if (!win_vld && cand[idx_v]) begin
        win_vld = 1'b1;
        win_idx = idx_v;
      end
    end
  end

  always_comb begin
    grt_c = '0;
    sel_c = '0;
    if (state_q == IDLE) begin
      if (win_vld && ok) begin
        grt_c[win_idx] = 1'b1;
        sel_c[win_idx] = 1'b1;
      end
    end else begin
      sel_c[owner_q] = 1'b1;
      grt_c[owner_q] = req_i[owner_q] & ok;
    end
  end

  assign grt_o   = rst_n ? grt_c : '0;
  assign sel_o   = rst_n ? sel_c : '0;
  assign valid_o = |grt_o;
  assign xfer    = valid_o;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cred_d  = cred_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (tail_i[win_idx]) begin
            ptr_d = inc_wrap(win_idx);
          end else begin
            state_d = LOCK;
            owner_d = win_idx;
          end
        end
      end
      LOCK: begin
        if (xfer && tail_i[owner_q]) begin
          state_d = IDLE;
          ptr_d   = inc_wrap(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
    // A return while already full means the downstream and this counter disagree.
    case ({xfer, credit_i})
      2'b10:   cred_d = cred_q - 1'b1;
      2'b01: begin
        if (cred_q == CMAX) err_d  = 1'b1;
        else                cred_d = cred_q + 1'b1;
      end
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cred_q  <= CMAX;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
    end
  end

  assign busy_o    = (state_q == LOCK);
  assign credits_o = cred_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_outport_alloc.sv
// Bench for outport_alloc: PORT_N=5, PORTID=2, CRED_N=4; cycle-by-cycle vector table plus reset sequence.
module tb_outport_alloc;
  import noc_pkg::*;

  localparam int N  = PORT_N;
  localparam int PW = PORT_W;
  localparam int CW = $clog2(4 + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_i, head_i, tail_i;
  logic [N*PW-1:0]   port_i;
  logic              credit_i;
  logic [N-1:0]      sel_o, grt_o;
  logic              valid_o, busy_o, err_o;
  logic [CW-1:0]     credits_o;

  always #5 clk = ~clk;

  outport_alloc #(.PORTID(2), .CRED_N(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .port_i(port_i), .head_i(head_i),
    .tail_i(tail_i), .credit_i(credit_i), .sel_o(sel_o), .grt_o(grt_o),
    .valid_o(valid_o), .busy_o(busy_o), .credits_o(credits_o), .err_o(err_o)
  );

  typedef struct {
    logic          rst;
    logic [N-1:0]  req, head, tail, off;
    logic          crd;
    logic [N-1:0]  grt, sel;
    logic          busy;
    logic [CW-1:0] cred;
    logic          err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   row   = 0;

  function automatic vec_t v(input logic rst, input logic [N-1:0] req, head, tail, off,
                             input logic crd, input logic [N-1:0] grt, sel,
                             input logic busy, input int cred, input logic err);
    vec_t x;
    x.rst = rst; x.req = req; x.head = head; x.tail = tail; x.off = off; x.crd = crd;
    x.grt = grt; x.sel = sel; x.busy = busy; x.cred = CW'(cred); x.err = err;
    return x;
  endfunction

  // Inputs flagged in off target port 4; all others target this instance's port 2.
  function automatic logic [N*PW-1:0] mkport(input logic [N-1:0] off);
    logic [N*PW-1:0] p;
    for (int i = 0; i < N; i++) p[i*PW +: PW] = off[i] ? PW'(4) : PW'(2);
    return p;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard row %0d: got empty queue expected an entry", row);
      return;
    end
    e = sb.pop_front();
    cmp("grt_o",     32'(grt_o),     32'(e.grt));
    cmp("sel_o",     32'(sel_o),     32'(e.sel));
    cmp("valid_o",   32'(valid_o),   32'(|e.grt));
    cmp("busy_o",    32'(busy_o),    32'(e.busy));
    cmp("credits_o", 32'(credits_o), 32'(e.cred));
    cmp("err_o",     32'(err_o),     32'(e.err));
  endtask

  task automatic apply(input vec_t x);
    @(posedge clk);
    #1;
    rst_n    = x.rst;
    req_i    = x.req;
    head_i   = x.head;
    tail_i   = x.tail;
    port_i   = mkport(x.off);
    credit_i = x.crd;
    sb.push_back(x);
    @(negedge clk);
    check_out();
    row++;
  endtask

  initial begin
    rst_n = 1'b0; req_i = '0; head_i = '0; tail_i = '0; port_i = '0; credit_i = 1'b0;

    //          rst req      head     tail     off      crd grt      sel      busy cred err
    // reset values, then two single-flit heads (inputs 0,2) served in order; ptr lands on 3
    tbl.push_back(v(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0));
    tbl.push_back(v(1, 5'b00101, 5'b00101, 5'b00101, 5'b00000, 0, 5'b00001, 5'b00001, 0, 4, 0));
    tbl.push_back(v(1, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 0, 3, 0));
    // ptr=3 picks input 4 over 0 and 2; transfer plus credit keeps count at 2
    tbl.push_back(v(1, 5'b10101, 5'b10101, 5'b10101, 5'b00000, 1, 5'b10000, 5'b10000, 0, 2, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 2, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0));
    // 3-flit packet on input 1; input 3 head waits until the cycle after the tail
    tbl.push_back(v(1, 5'b00010, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 5'b00010, 0, 4, 0));
    tbl.push_back(v(1, 5'b01010, 5'b01000, 5'b01000, 5'b00000, 0, 5'b00010, 5'b00010, 1, 3, 0));
    tbl.push_back(v(1, 5'b01010, 5'b01000, 5'b01010, 5'b00000, 0, 5'b00010, 5'b00010, 1, 2, 0));
    tbl.push_back(v(1, 5'b01000, 5'b01000, 5'b01000, 5'b00000, 1, 5'b01000, 5'b01000, 0, 1, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 1, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 2, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3, 0));
    // 6-flit packet on input 0 with no credit returns: stalls after 4 flits
    tbl.push_back(v(1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 0, 5'b00001, 5'b00001, 0, 4, 0));
    tbl.push_back(v(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00001, 5'b00001, 1, 3, 0));
    tbl.push_back(v(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00001, 5'b00001, 1, 2, 0));
    tbl.push_back(v(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00001, 5'b00001, 1, 1, 0));
    tbl.push_back(v(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00001, 1, 0, 0));
    tbl.push_back(v(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00001, 1, 0, 0));
    tbl.push_back(v(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00001, 5'b00001, 1, 1, 0));
    tbl.push_back(v(1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 0, 5'b00000, 5'b00001, 1, 0, 0));
    tbl.push_back(v(1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 1, 5'b00000, 5'b00001, 1, 0, 0));
    tbl.push_back(v(1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 0, 5'b00001, 5'b00001, 1, 1, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 1, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 2, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3, 0));
    // credit at full count: saturate and raise sticky error
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 4, 0));
    tbl.push_back(v(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 1));
    // input 0 addressed elsewhere never wins, even alone or against input 1
    tbl.push_back(v(1, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00000, 5'b00000, 0, 4, 1));
    tbl.push_back(v(1, 5'b00001, 5'b00001, 5'b00000, 5'b00001, 0, 5'b00000, 5'b00000, 0, 4, 1));
    tbl.push_back(v(1, 5'b00011, 5'b00011, 5'b00011, 5'b00001, 0, 5'b00010, 5'b00010, 0, 4, 1));
    tbl.push_back(v(1, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00000, 5'b00000, 0, 3, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset mid-packet owned by input 1: lock dropped, counters restored, new head on 2 wins at once.
    apply(v(1, 5'b00010, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 5'b00010, 0, 3, 1));
    apply(v(1, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00010, 5'b00010, 1, 2, 1));
    apply(v(0, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0));
    apply(v(1, 5'b00110, 5'b00100, 5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 0, 4, 0));
    apply(v(1, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 3, 0));

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
